// File: rtl/alu_muldiv.sv
// Handshaked ALU: single-cycle base integer ops plus iterative RV32M/RV64M
// multiply (shift-add) and divide (restoring) over XLEN cycles.
module alu_muldiv #(
   parameter  int XLEN = 32,
   localparam int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   input  logic [4:0]      control,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [SHW:0]    LAST    = (SHW+1)'(XLEN-1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]         state;
   logic [SHW:0]       cnt;
   logic [2*XLEN-1:0]  acc;
   logic [2*XLEN-1:0]  acc_next;
   logic [XLEN-1:0]    opnd;
   logic               neg_r;
   logic               rneg_r;
   logic               sel_r;

   logic               accept;
   logic               is_mul;
   logic               is_div;
   logic               div_sgn;
   logic               div0;
   logic               ovf;
   logic               long_start;
   logic               sgn1;
   logic               sgn2;
   logic               n1;
   logic               n2;
   logic               cmp;
   logic [SHW-1:0]     shamt;
   logic [XLEN-1:0]    mag1;
   logic [XLEN-1:0]    mag2;
   logic [XLEN-1:0]    base_res;
   logic [XLEN-1:0]    quick_res;
   logic [XLEN-1:0]    fin;
   logic [XLEN-1:0]    quo;
   logic [XLEN-1:0]    rmd;
   logic [XLEN:0]      sum;
   logic [XLEN:0]      trial;
   logic [2*XLEN-1:0]  prod;

   assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == S_DONE);
   assign busy      = (state == S_MUL) || (state == S_DIV);

   assign shamt   = op2[SHW-1:0];
   assign is_mul  = (control[4:2] == 3'b100);
   assign is_div  = (control[4:2] == 3'b101);
   assign div_sgn = ~control[0];
   assign div0    = (op2 == '0);
   assign ovf     = div_sgn && (op1 == MIN_NEG) && (op2 == '1);
   assign long_start = is_mul || (is_div && !div0 && !ovf);

   // Operand signedness: mulh s*s, mulhsu s*u, mul/mulhu unsigned; div/rem signed
   assign sgn1 = is_mul ? (control[1] ^ control[0]) : div_sgn;
   assign sgn2 = is_mul ? (control[1:0] == 2'b01) : div_sgn;
   assign n1   = sgn1 && op1[XLEN-1];
   assign n2   = sgn2 && op2[XLEN-1];
   assign mag1 = n1 ? -op1 : op1;
   assign mag2 = n2 ? -op2 : op2;

   always_comb begin
      base_res = '0;
      cmp      = 1'b0;
      case (control[3:0])
         4'd0:  base_res = op1 + op2;
         4'd1:  base_res = op1 - op2;
         4'd2:  base_res = op1 << shamt;
         4'd3:  cmp = ($signed(op1) < $signed(op2));
         4'd4:  cmp = (op1 < op2);
         4'd5:  base_res = op1 ^ op2;
         4'd6:  base_res = $unsigned($signed(op1) >>> shamt);
         4'd7:  base_res = op1 >> shamt;
         4'd8:  base_res = op1 | op2;
         4'd9:  base_res = op1 & op2;
         4'd10: cmp = (op1 == op2);
         4'd11: cmp = (op1 != op2);
         4'd12: cmp = ($signed(op1) >= $signed(op2));
         4'd13: cmp = (op1 >= op2);
         default: base_res = '0;
      endcase
      if (control[3:0] inside {4'd3, 4'd4, 4'd10, 4'd11, 4'd12, 4'd13})
         base_res = {{(XLEN-1){1'b0}}, cmp};
   end

   always_comb begin
      quick_res = '0;
      if (!control[4]) begin
         quick_res = base_res;
      end else if (is_div) begin
         if (div0)
            quick_res = control[1] ? op1 : '1;
         else if (ovf)
            quick_res = control[1] ? '0 : op1;
      end
   end

   // acc is {upper, lower}: mul keeps partial product / remaining multiplier,
   // div keeps partial remainder / dividend shifting into quotient.
   always_comb begin
      sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opnd};
      if (state == S_MUL)
         acc_next = {sum, acc[XLEN-1:1]};
      else if (trial[XLEN])
         acc_next = {acc[2*XLEN-2:0], 1'b0};
      else
         acc_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      prod = neg_r ? -acc_next : acc_next;
      quo  = neg_r ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
      rmd  = rneg_r ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
      if (state == S_MUL)
         fin = sel_r ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
      else
         fin = sel_r ? rmd : quo;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         result <= '0;
         zero   <= 1'b1;
         cnt    <= '0;
         acc    <= '0;
         opnd   <= '0;
         neg_r  <= 1'b0;
         rneg_r <= 1'b0;
         sel_r  <= 1'b0;
      end else begin
         case (state)
            S_MUL, S_DIV: begin
               acc <= acc_next;
               if (cnt == LAST) begin
                  state  <= S_DONE;
                  result <= fin;
                  zero   <= (fin == '0);
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               if (accept) begin
                  if (long_start) begin
                     state  <= is_mul ? S_MUL : S_DIV;
                     cnt    <= '0;
                     opnd   <= is_mul ? mag1 : mag2;
                     acc    <= {{XLEN{1'b0}}, (is_mul ? mag2 : mag1)};
                     neg_r  <= n1 ^ n2;
                     rneg_r <= n1;
                     sel_r  <= is_mul ? (control[1:0] != 2'b00) : control[1];
                  end else begin
                     // Single-cycle path: result lands at the accept edge
                     state  <= S_DONE;
                     result <= quick_res;
                     zero   <= (quick_res == '0);
                  end
               end else if ((state == S_DONE) && out_ready) begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: directed table, backpressure/streaming,
// randomized ops against a plain-arithmetic reference, and mid-op reset.
module tb_alu_muldiv;

   localparam int XLEN = 32;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic [4:0]      control;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            busy;

   alu_muldiv #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op1(op1), .op2(op2), .control(control), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
   );

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [4:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   exp_t q[$];
   int   total = 0;
   int   passed = 0;
   int   cyc = 0;
   int   bstart = 1;
   int   bend = 0;
   int   vstart = 0;
   bit   new_item = 1'b1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [31:0] model(input logic [4:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, ub;
      logic [63:0] p;
      logic signed [31:0] t;
      sa = $signed(a);
      sb = $signed(b);
      ub = {32'b0, b};
      case (c)
         5'd0:  return a + b;
         5'd1:  return a - b;
         5'd2:  return a << b[4:0];
         5'd3:  return {31'b0, sa < sb};
         5'd4:  return {31'b0, a < b};
         5'd5:  return a ^ b;
         5'd6:  begin t = a; return t >>> b[4:0]; end
         5'd7:  return a >> b[4:0];
         5'd8:  return a | b;
         5'd9:  return a & b;
         5'd10: return {31'b0, a == b};
         5'd11: return {31'b0, a != b};
         5'd12: return {31'b0, sa >= sb};
         5'd13: return {31'b0, a >= b};
         5'd16: begin p = sa * sb; return p[31:0]; end
         5'd17: begin p = sa * sb; return p[63:32]; end
         5'd18: begin p = sa * ub; return p[63:32]; end
         5'd19: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         5'd20: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(sa / sb);
         end
         5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         5'd22: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
         5'd23: return (b == 0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int model_lat(input logic [4:0] c, input logic [31:0] a,
                                    input logic [31:0] b);
      if (c >= 5'd16 && c <= 5'd19) return XLEN + 1;
      if (c >= 5'd20 && c <= 5'd23) begin
         if (b == 0) return 1;
         if (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
         return XLEN + 1;
      end
      return 1;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   // mode 0: out_ready=1, 1: random out_ready, 2: leave out_ready untouched
   task automatic issue(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input int mode);
      exp_t e;
      int n;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      control  = c;
      op1      = a;
      op2      = b;
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            e.res = exp;
            e.cyc = cyc + lat;
            q.push_back(e);
            if (lat > 1) begin
               bstart = cyc + 1;
               bend   = cyc + XLEN;
            end
            break;
         end
         n++;
         if (n > 200) begin
            chk("accept_timeout", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b0;
            break;
         end
         @(posedge clk);
         #1;
         if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic drain();
      int n;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", q.size(), 32'd0);
      @(negedge clk);
   endtask

   // Monitor: pops the scoreboard on every transfer
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         new_item = 1'b1;
      end else begin
         chk("busy", {31'b0, busy}, {31'b0, (cyc >= bstart && cyc <= bend)});
         if (out_valid) begin
            if (new_item) begin
               vstart   = cyc;
               new_item = 1'b0;
            end
            if (out_ready) begin
               chk("outstanding_items", {31'b0, q.size() != 0}, 32'd1);
               if (q.size() != 0) begin
                  e = q.pop_front();
                  chk("result", result, e.res);
                  chk("zero", {31'b0, zero}, {31'b0, e.res == 32'd0});
                  chk("latency_cycle", vstart, e.cyc);
               end
               new_item = 1'b1;
            end
         end
      end
   end

   vec_t dir[16];
   logic [31:0] stable_res;
   int c0;
   int nval;

   initial begin
      dir[0]  = '{5'd0,  32'd5,          32'd7,          32'd12,         1};
      dir[1]  = '{5'd1,  32'd7,          32'd7,          32'd0,          1};
      dir[2]  = '{5'd6,  32'h8000_0000,  32'h21,         32'hC000_0000,  1};
      dir[3]  = '{5'd3,  32'hFFFF_FFFF,  32'd1,          32'd1,          1};
      dir[4]  = '{5'd4,  32'hFFFF_FFFF,  32'd1,          32'd0,          1};
      dir[5]  = '{5'd19, 32'hFFFF_FFFF,  32'd2,          32'd1,          33};
      dir[6]  = '{5'd17, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  33};
      dir[7]  = '{5'd16, 32'h1_0000,     32'h1_0000,     32'd0,          33};
      dir[8]  = '{5'd20, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
      dir[9]  = '{5'd22, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
      dir[10] = '{5'd21, 32'd100,        32'd7,          32'd14,         33};
      dir[11] = '{5'd23, 32'd100,        32'd7,          32'd2,          33};
      dir[12] = '{5'd21, 32'd10,         32'd0,          32'hFFFF_FFFF,  1};
      dir[13] = '{5'd23, 32'd10,         32'd0,          32'd10,         1};
      dir[14] = '{5'd20, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
      dir[15] = '{5'd22, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op1 = '0; op2 = '0; control = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_zero", {31'b0, zero}, 32'd1);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

      foreach (dir[i]) issue(dir[i].c, dir[i].a, dir[i].b, dir[i].exp, dir[i].lat, 0);
      drain();

      // Backpressure then streaming
      @(posedge clk);
      #1 out_ready = 1'b0;
      issue(5'd0, 32'd5, 32'd7, 32'd12, 1, 2);
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
         chk("hold_result", result, 32'd12);
         chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
      end
      for (int k = 0; k < 4; k++) begin
         logic [31:0] a, b;
         a = $urandom_range(0, 1000);
         b = $urandom_range(0, 1000);
         issue(5'd0, a, b, a + b, 1, 0);
      end
      drain();

      for (int k = 0; k < 200; k++) begin
         logic [4:0] c;
         logic [31:0] a, b;
         c = 5'($urandom_range(0, 31));
         a = pick();
         b = pick();
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1 in_valid = 1'b0;
         end
         issue(c, a, b, model(c, a, b), model_lat(c, a, b), 1);
      end
      drain();

      // Reset in cycle 10 of a divide
      issue(5'd20, 32'd1000, 32'd3, 32'd333, 33, 0);
      c0 = cyc;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      bend  = cyc;
      q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("abort_cycle", cyc, c0 + 11);
      chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
      chk("abort_result", result, 32'd0);
      chk("abort_zero", {31'b0, zero}, 32'd1);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
      nval = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) nval++;
      end
      chk("stale_out_valid_cycles", nval, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised, handshaked successor to the single-cycle datapath ALU. It executes all 14 base integer ALU operations with one-cycle latency. It adds the RV32M/RV64M multiply, divide and remainder operations, computed iteratively over XLEN cycles. It sits between the decode/register-read stage and writeback in the multi-cycle core, and the valid/ready handshakes let the control unit stall on long operations.

## Interface
- XLEN, 32, operand/result width; power of two, ≥ 8
- SHW, $clog2(XLEN), shift-amount width (derived, not overridable)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands and control are valid
- in_ready  out  1  block accepts an operation this cycle
- op1  in  XLEN  operand 1 (rs1 / dividend / multiplicand)
- op2  in  XLEN  operand 2 (rs2/imm, divisor, multiplier)
- control  in  5  operation code, see Operation
- out_valid  out  1  result is valid
- out_ready  in  1  consumer takes result this cycle
- result  out  XLEN  registered result
- zero  out  1  registered, equals (result == 0)
- busy  out  1  high in MUL or DIV state

## Operation
- Accept occurs when in_valid && in_ready at a rising edge. op1, op2 and control are captured; they are don't-care afterwards.
- Base codes (control[4]=0):
  - 00000 add, 00001 sub, 00010 sll
  - 00011 slt (signed), 00100 sltu
  - 00101 xor, 00110 sra, 00111 srl
  - 01000 or, 01001 and
  - 01010 eq, 01011 ne, 01100 ge (signed), 01101 geu
- Shifts use op2[SHW-1:0] only.
- Compare results are zero-extended 0/1.
- Codes 01110 and 01111 are undefined: result 0.
- M codes (control[4]=1):
  - 10000 mul: low XLEN bits
  - 10001 mulh: s×s, high
  - 10010 mulhsu: s×u, high
  - 10011 mulhu: u×u, high
  - 10100 div, 10101 divu, 10110 rem, 10111 remu
- Codes 11000–11111 are undefined: result 0, one-cycle latency.
- Multiply:
  - Unsigned shift-add on operand magnitudes, one multiplier bit per cycle, 2·XLEN-bit accumulator.
  - The two's-complement negate of the product applies when the operand signs differ (signed ops only).
- Divide: restoring, one quotient bit per cycle on magnitudes.
  - Quotient sign = sign(op1) XOR sign(op2).
  - Remainder sign = sign(op1).
  - Truncation toward zero.
- Special cases, resolved at accept with no iteration:
  - divisor 0: div/divu → all ones; rem/remu → op1
  - div overflow (op1 = most-negative, op2 = −1, signed): div → op1; rem → 0
- States:
  - IDLE → EXEC1 on a base, undefined or special-case accept
  - IDLE → MUL on a multiply accept
  - IDLE → DIV on a normal div/rem accept
  - MUL/DIV: XLEN iteration cycles, then → DONE
  - EXEC1 → DONE, collapsed: the result is written at the accept edge and the state goes straight to DONE
  - DONE → IDLE when out_ready and no new accept
  - DONE → DONE/MUL/DIV when out_ready and a new accept occurs in the same cycle

## Timing
- Reset, while rst_n low at an edge:
  - state IDLE, out_valid 0, result 0, zero 1, busy 0
  - in_ready 1 in the cycle after reset
- Reset has priority over everything. Asserting rst_n low mid-MUL/DIV aborts the operation; no out_valid is produced for it.
- Accept edge = end of cycle 0.
- Base, undefined and special-case ops: out_valid high in cycle 1.
- MUL/DIV ops: busy high cycles 1..XLEN; out_valid high in cycle XLEN+1 (33 for XLEN=32).
- in_ready:
  - 1 in IDLE
  - 1 in DONE only when out_ready is 1 in the same cycle (combinational from out_ready)
  - 0 in MUL/DIV
- This gives back-to-back base ops at one per cycle.
- Backpressure: while out_valid && !out_ready, result and zero hold stable and out_valid stays high.
- out_valid drops the cycle after the transfer unless a new base result replaces it.
- result and zero update only at the edge where out_valid rises; zero is never combinational.
- Iteration counter is SHW+1 bits, counting 0..XLEN-1. No wrap side effects.

## Test plan
- Base ops, XLEN=32:
  - add 5+7 → result 12, zero 0, out_valid in cycle 1
  - sub 7−7 → 0, zero 1
  - sra 0x80000000 by op2=0x21 → 0xC0000000 (amount 1)
  - slt −1 < 1 → 1; sltu → 0
- Multiply:
  - mulhu 0xFFFFFFFF×2 → 0x00000001
  - mulh −1×2 → 0xFFFFFFFF
  - mul 0x10000×0x10000 → 0
  - each with out_valid exactly in cycle 33 and busy high cycles 1..32
- Divide:
  - div −7/2 → 0xFFFFFFFD; rem → 0xFFFFFFFF
  - divu 100/7 → 14; remu → 2
  - all in cycle 33
- Special cases:
  - divu 10/0 → 0xFFFFFFFF; remu 10/0 → 10
  - div 0x80000000/−1 → 0x80000000; rem → 0
  - all in cycle 1
- Handshake:
  - Hold out_ready 0 for 5 cycles after out_valid → result stable, in_ready 0.
  - Then stream 4 adds with in_valid = out_ready = 1 → 4 results on 4 consecutive cycles.
- Reset: drop rst_n at cycle 10 of a div → next cycle out_valid 0, result 0, zero 1, busy 0, in_ready 1; no stale result later.
